// File: rtl/vram_port_arbiter_if.sv
// vram_port_arbiter_if: capture-write, scanout-read and VRAM signals of the VRAM port arbiter.
// slave is the arbiter's view; master is the view of whatever drives the requesters and RAM.
interface vram_port_arbiter_if #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              i_wrValid;
  logic              o_wrReady;
  logic [ADDR_W-1:0] i_wrAddr;
  logic [DATA_W-1:0] i_wrData;
  logic              i_rdValid;
  logic              o_rdReady;
  logic [ADDR_W-1:0] i_rdAddr;
  logic [DATA_W-1:0] o_rdData;
  logic              o_rdDataValid;
  logic [ADDR_W-1:0] o_ramAddr;
  logic              o_ramWe;
  logic [DATA_W-1:0] o_ramDin;
  logic [DATA_W-1:0] i_ramDout;
  logic [LVL_W-1:0]  o_fifoLevel;

  modport slave (
    input  i_wrValid, i_wrAddr, i_wrData, i_rdValid, i_rdAddr, i_ramDout,
    output o_wrReady, o_rdReady, o_rdData, o_rdDataValid, o_ramAddr, o_ramWe, o_ramDin,
           o_fifoLevel
  );

  modport master (
    output i_wrValid, i_wrAddr, i_wrData, i_rdValid, i_rdAddr, i_ramDout,
    input  o_wrReady, o_rdReady, o_rdData, o_rdDataValid, o_ramAddr, o_ramWe, o_ramDin,
           o_fifoLevel
  );
endinterface

// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter: shares the single-port 160x144 VRAM between scanout reads (priority)
// and capture writes (buffered in a small FIFO, drained in cycles with no read).
// Optional feature macro: VRAM_ARB_WR_GUARD_EN -- after WR_GUARD_LIMIT consecutive read grants
// with writes pending, one write slot is forced. Undefined: strict read priority.
module vram_port_arbiter #(
  parameter int ADDR_W         = 15,
  parameter int DATA_W         = 8,
  parameter int MEM_DEPTH      = 23040,
  parameter int FIFO_DEPTH     = 4,
  parameter int WR_GUARD_LIMIT = 8
) (
  input  logic               i_clk,
  input  logic               i_rstN,
  vram_port_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   MEM_LIMIT = (ADDR_W + 1)'(MEM_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_e;

  // Address lies inside the 160x144 frame; one extra bit keeps MEM_DEPTH == 2**ADDR_W legal
  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < MEM_LIMIT);
  endfunction

  state_e             state_r;
  state_e             next_state_s;
  logic               run_r;
  logic               rd_ready_s;
  logic               rd_oor_s;
  logic               pop_s;
  logic               wr_issue_s;
  logic               push_s;
  logic               fifo_empty_s;
  logic               force_wr_s;

  logic [ADDR_W-1:0]  fifo_addr_r [FIFO_DEPTH];
  logic [DATA_W-1:0]  fifo_data_r [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [LVL_W-1:0]   level_r;
  logic [LVL_W-1:0]   level_nxt_s;
  logic               wr_ready_r;
  logic [ADDR_W-1:0]  head_addr_s;
  logic [DATA_W-1:0]  head_data_s;

  logic [ADDR_W-1:0]  ram_addr_r;
  logic               ram_we_r;
  logic [DATA_W-1:0]  ram_din_r;
  logic               rd_oor_p1_r;
  logic               rd_valid_p2_r;
  logic               rd_oor_p2_r;

  assign push_s       = bus.i_wrValid & wr_ready_r;
  assign fifo_empty_s = (level_r == {LVL_W{1'b0}});
  assign head_addr_s  = fifo_addr_r[rd_ptr_r];
  assign head_data_s  = fifo_data_r[rd_ptr_r];

  assign bus.o_wrReady     = wr_ready_r;
  assign bus.o_rdReady     = rd_ready_s;
  assign bus.o_rdDataValid = rd_valid_p2_r;
  // RAM data arrives in the same cycle as the valid; zero it for out-of-range or idle slots
  assign bus.o_rdData      = (rd_valid_p2_r && !rd_oor_p2_r) ? bus.i_ramDout : {DATA_W{1'b0}};
  assign bus.o_ramAddr     = ram_addr_r;
  assign bus.o_ramWe       = ram_we_r;
  assign bus.o_ramDin      = ram_din_r;
  assign bus.o_fifoLevel   = level_r;

`ifdef VRAM_ARB_WR_GUARD_EN
  localparam int GCNT_W = $clog2(WR_GUARD_LIMIT + 1);
  localparam logic [GCNT_W-1:0] GUARD_MAX = GCNT_W'(WR_GUARD_LIMIT);

  logic [GCNT_W-1:0] guard_cnt_r;

  assign force_wr_s = (guard_cnt_r == GUARD_MAX) && !fifo_empty_s;

  // Count back-to-back read grants that left a write waiting; any other slot clears it
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      guard_cnt_r <= {GCNT_W{1'b0}};
    end else if ((next_state_s == ST_RD) && !fifo_empty_s) begin
      guard_cnt_r <= guard_cnt_r + GCNT_W'(1);
    end else begin
      guard_cnt_r <= {GCNT_W{1'b0}};
    end
  end
`else
  assign force_wr_s = 1'b0;
`endif

  // Issue state: remembers last cycle's operation; run_r holds off grants until out of reset
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      state_r <= ST_IDLE;
      run_r   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      run_r   <= 1'b1;
    end
  end

  // Per-cycle issue decision: forced write slot, then read, then FIFO drain, else idle
  always_comb begin
    next_state_s = ST_IDLE;
    if (!run_r) begin
      next_state_s = ST_IDLE;
    end else if (force_wr_s) begin
      next_state_s = ST_WR;
    end else if (bus.i_rdValid) begin
      next_state_s = ST_RD;
    end else if (!fifo_empty_s) begin
      next_state_s = ST_WR;
    end else begin
      next_state_s = ST_IDLE;
    end
  end

  // Decode the issued operation into grant, pop and RAM-write qualifiers
  always_comb begin
    rd_ready_s = 1'b0;
    rd_oor_s   = 1'b0;
    pop_s      = 1'b0;
    wr_issue_s = 1'b0;
    case (next_state_s)
      ST_RD: begin
        rd_ready_s = 1'b1;
        rd_oor_s   = !in_range(bus.i_rdAddr);
      end
      ST_WR: begin
        pop_s      = 1'b1;
        wr_issue_s = in_range(head_addr_s);
      end
      ST_IDLE: begin
        rd_ready_s = 1'b0;
      end
      default: begin
        rd_ready_s = 1'b0;
      end
    endcase
  end

  // FIFO level change from this cycle's push/pop pair
  always_comb begin
    level_nxt_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LVL_W'(1);
      2'b01:   level_nxt_s = level_r - LVL_W'(1);
      default: level_nxt_s = level_r;
    endcase
  end

  // Write FIFO payload; stale entries are harmless because pointers and level gate them
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      fifo_addr_r[wr_ptr_r] <= bus.i_wrAddr;
      fifo_data_r[wr_ptr_r] <= bus.i_wrData;
    end
  end

  // FIFO pointers, level and ready; ready reflects level only, never a same-cycle pop
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      level_r    <= {LVL_W{1'b0}};
      wr_ready_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      level_r    <= level_nxt_s;
      wr_ready_r <= (level_nxt_s != FULL_LVL);
    end
  end

  // Registered VRAM command; idle and discarded writes keep the address and data stable
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      ram_addr_r <= {ADDR_W{1'b0}};
      ram_we_r   <= 1'b0;
      ram_din_r  <= {DATA_W{1'b0}};
    end else begin
      case (next_state_s)
        ST_RD: begin
          ram_addr_r <= bus.i_rdAddr;
          ram_we_r   <= 1'b0;
        end
        ST_WR: begin
          if (wr_issue_s) begin
            ram_addr_r <= head_addr_s;
            ram_din_r  <= head_data_s;
            ram_we_r   <= 1'b1;
          end else begin
            ram_we_r   <= 1'b0;
          end
        end
        default: begin
          ram_we_r <= 1'b0;
        end
      endcase
    end
  end

  // Read return pipeline: address cycle, then data cycle two clocks after the grant
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      rd_oor_p1_r   <= 1'b0;
      rd_valid_p2_r <= 1'b0;
      rd_oor_p2_r   <= 1'b0;
    end else begin
      rd_oor_p1_r   <= rd_oor_s;
      rd_valid_p2_r <= (state_r == ST_RD);
      rd_oor_p2_r   <= rd_oor_p1_r;
    end
  end
endmodule

// File: tb/tb_vram_port_arbiter.sv
// tb_vram_port_arbiter: table-driven reads/writes plus hand-written sequences for backpressure,
// the optional write guard (VRAM_ARB_WR_GUARD_EN) and mid-operation reset.
module tb_vram_port_arbiter;
  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  vram_port_arbiter_if #(.ADDR_W(15), .DATA_W(8), .FIFO_DEPTH(4)) vif ();

  vram_port_arbiter #(
    .ADDR_W(15), .DATA_W(8), .MEM_DEPTH(23040), .FIFO_DEPTH(4), .WR_GUARD_LIMIT(8)
  ) dut (
    .i_clk  (clk),
    .i_rstN (rst_n),
    .bus    (vif.slave)
  );

  typedef struct { int cyc; logic [7:0] data; } rd_exp_t;
  typedef struct { int cyc; logic [14:0] addr; logic [7:0] data; } we_ev_t;
  typedef struct { logic [14:0] addr; logic [7:0] data; } rd_vec_t;
  typedef struct { logic [14:0] addr; logic [7:0] data; bit exp_we; } wr_vec_t;

  rd_exp_t     sb[$];
  we_ev_t      we_log[$];
  rd_exp_t     mon_e;
  we_ev_t      we_e;
  logic [7:0]  wmem [int];
  logic [7:0]  ram_dout;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pat(input logic [14:0] a);
    return a[7:0] ^ 8'h3C;
  endfunction

  // Synchronous-read VRAM model: unwritten words read back as pat(addr)
  always @(posedge clk) begin
    ram_dout <= wmem.exists(int'(vif.o_ramAddr)) ? wmem[int'(vif.o_ramAddr)] : pat(vif.o_ramAddr);
    if (vif.o_ramWe) wmem[int'(vif.o_ramAddr)] = vif.o_ramDin;
  end
  assign vif.i_ramDout = ram_dout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sb_push(input int c, input logic [7:0] d);
    rd_exp_t e;
    e.cyc  = c;
    e.data = d;
    sb.push_back(e);
  endtask

  // Read-return scoreboard and RAM-write log
  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL rd_missing: no valid at cycle %0d, now %0d", sb[0].cyc, cyc);
        sb.delete(0);
      end
      if (vif.o_rdDataValid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected: valid with data 0x%0h at cycle %0d, none expected",
                   vif.o_rdData, cyc);
        end else begin
          mon_e = sb[0];
          sb.delete(0);
          chk("rd_cycle", cyc, mon_e.cyc);
          chk("rd_data", vif.o_rdData, mon_e.data);
        end
      end
      if (vif.o_ramWe) begin
        we_e.cyc  = cyc;
        we_e.addr = vif.o_ramAddr;
        we_e.data = vif.o_ramDin;
        we_log.push_back(we_e);
      end
    end
  end

  task automatic push_wr(input logic [14:0] a, input logic [7:0] d);
    bit done;
    done = 1'b0;
    @(negedge clk);
    vif.i_wrValid = 1'b1;
    vif.i_wrAddr  = a;
    vif.i_wrData  = d;
    for (int n = 0; n < 50 && !done; n++) begin
      #1;
      if (vif.o_wrReady) done = 1'b1;
      @(negedge clk);
    end
    vif.i_wrValid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL push_wr_timeout: addr 0x%0h not accepted, expected accept", a);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    rd_vec_t rd_tab[7];
    wr_vec_t wr_tab[3];
    int      b;
    int      wi;
    int      acc_j;
    int      d_cyc;

    rd_tab[0] = '{15'd5,     8'hA5};
    rd_tab[1] = '{15'd100,   8'h58};
    rd_tab[2] = '{15'd0,     8'hC7};
    rd_tab[3] = '{15'd23039, 8'h5A};
    rd_tab[4] = '{15'd23040, 8'h00};
    rd_tab[5] = '{15'd32767, 8'h00};
    rd_tab[6] = '{15'd101,   8'h59};
    wr_tab[0] = '{15'd23039, 8'h5A, 1'b1};
    wr_tab[1] = '{15'd23040, 8'h11, 1'b0};
    wr_tab[2] = '{15'd0,     8'hC7, 1'b1};

    cyc = 0; checks = 0; errors = 0;
    rst_n = 1'b0;
    vif.i_wrValid = 1'b0; vif.i_wrAddr = 15'd0; vif.i_wrData = 8'd0;
    vif.i_rdValid = 1'b1; vif.i_rdAddr = 15'd7;

    // Reset state (read requested during reset must not be granted)
    repeat (3) @(negedge clk);
    #1;
    chk("rst_wr_ready", vif.o_wrReady, 1'b0);
    chk("rst_rd_ready", vif.o_rdReady, 1'b0);
    chk("rst_rd_data", vif.o_rdData, 8'h00);
    chk("rst_rd_valid", vif.o_rdDataValid, 1'b0);
    chk("rst_ram_addr", vif.o_ramAddr, 15'd0);
    chk("rst_ram_we", vif.o_ramWe, 1'b0);
    chk("rst_ram_din", vif.o_ramDin, 8'h00);
    chk("rst_level", vif.o_fifoLevel, 3'd0);
    vif.i_rdValid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("post_rst_wr_ready", vif.o_wrReady, 1'b1);

    // Single read of address 100: address next cycle, data two cycles after grant
    @(negedge clk);
    vif.i_rdValid = 1'b1; vif.i_rdAddr = 15'd100;
    #1;
    chk("t1_grant", vif.o_rdReady, 1'b1);
    if (vif.o_rdReady) sb_push(cyc + 2, 8'h58);
    @(negedge clk);
    vif.i_rdValid = 1'b0;
    #1;
    chk("t1_ram_addr", vif.o_ramAddr, 15'd100);
    chk("t1_ram_we", vif.o_ramWe, 1'b0);
    repeat (3) @(negedge clk);

    // Write (5, A5) with no reads: pop the cycle after the push, RAM write the cycle after that
    push_wr(15'd5, 8'hA5);
    #1;
    chk("t2_level_1", vif.o_fifoLevel, 3'd1);
    chk("t2_we_before", vif.o_ramWe, 1'b0);
    @(negedge clk);
    #1;
    chk("t2_we", vif.o_ramWe, 1'b1);
    chk("t2_ram_addr", vif.o_ramAddr, 15'd5);
    chk("t2_ram_din", vif.o_ramDin, 8'hA5);
    chk("t2_level_0", vif.o_fifoLevel, 3'd0);

    // Write table, including an out-of-range address that must be dropped
    for (int i = 0; i < 3; i++) begin
      b = we_log.size();
      push_wr(wr_tab[i].addr, wr_tab[i].data);
      repeat (3) @(negedge clk);
      chk("wr_tab_we_count", we_log.size() - b, wr_tab[i].exp_we ? 1 : 0);
      if (wr_tab[i].exp_we && we_log.size() > b) begin
        chk("wr_tab_addr", we_log[b].addr, wr_tab[i].addr);
        chk("wr_tab_data", we_log[b].data, wr_tab[i].data);
      end
    end

    // Read table, back to back one per cycle
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      vif.i_rdValid = 1'b1; vif.i_rdAddr = rd_tab[i].addr;
      #1;
      chk("rd_tab_grant", vif.o_rdReady, 1'b1);
      if (vif.o_rdReady) sb_push(cyc + 2, rd_tab[i].data);
    end
    @(negedge clk);
    vif.i_rdValid = 1'b0;
    repeat (4) @(negedge clk);
    chk("rd_tab_drained", sb.size(), 0);

`ifdef VRAM_ARB_WR_GUARD_EN
    // Guard: with writes pending, every ninth cycle is a forced write slot
    for (int k = -1; k < 36; k++) begin
      @(negedge clk);
      vif.i_rdValid = 1'b1; vif.i_rdAddr = 15'd200;
      vif.i_wrValid = (k < 3); vif.i_wrAddr = 15'(401 + k); vif.i_wrData = 8'(k + 33);
      #1;
      chk("guard_rd_ready", vif.o_rdReady, !(k >= 0 && (k % 9) == 8));
      if (vif.o_rdReady) sb_push(cyc + 2, pat(15'd200));
      if (k >= 0) chk("guard_ram_we", vif.o_ramWe, (k >= 1 && ((k - 1) % 9) == 8));
    end
    @(negedge clk);
    vif.i_rdValid = 1'b0; vif.i_wrValid = 1'b0;
    #1;
    chk("guard_last_we", vif.o_ramWe, 1'b1);
    chk("guard_level_0", vif.o_fifoLevel, 3'd0);
    repeat (4) @(negedge clk);
`else
    // Backpressure: reads held high, five writes offered; four fill the FIFO, none drain
    b = we_log.size();
    wi = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      vif.i_rdValid = 1'b1; vif.i_rdAddr = 15'd200;
      vif.i_wrValid = (wi < 5); vif.i_wrAddr = 15'(300 + wi); vif.i_wrData = 8'(16 + wi);
      #1;
      chk("t3_rd_grant", vif.o_rdReady, 1'b1);
      if (vif.o_rdReady) sb_push(cyc + 2, pat(15'd200));
      if (vif.i_wrValid && vif.o_wrReady) wi++;
    end
    chk("t3_accepted", wi, 4);
    chk("t3_no_write", we_log.size() - b, 0);
    acc_j = -1;
    d_cyc = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      vif.i_rdValid = 1'b0;
      if (acc_j >= 0) vif.i_wrValid = 1'b0;
      #1;
      if (j == 0) begin
        d_cyc = cyc;
        chk("t3_full_level", vif.o_fifoLevel, 3'd4);
        chk("t3_full_ready", vif.o_wrReady, 1'b0);
        chk("t3_no_rd_grant", vif.o_rdReady, 1'b0);
      end
      if (vif.i_wrValid && vif.o_wrReady && acc_j < 0) acc_j = j;
    end
    chk("t3_fifth_accept", acc_j, 1);
    chk("t3_drain_count", we_log.size() - b, 5);
    for (int i = 0; i < 5; i++) begin
      if (we_log.size() > b + i) begin
        chk("t3_drain_cycle", we_log[b + i].cyc, d_cyc + 1 + i);
        chk("t3_drain_addr", we_log[b + i].addr, 15'(300 + i));
        chk("t3_drain_data", we_log[b + i].data, 8'(16 + i));
      end
    end
`endif

    // Reset with three queued writes and two reads in flight
    @(negedge clk);
    vif.i_rdValid = 1'b1; vif.i_rdAddr = 15'd50;
    for (int k = 0; k < 3; k++) begin
      vif.i_wrValid = 1'b1; vif.i_wrAddr = 15'(600 + k); vif.i_wrData = 8'(k + 96);
      #1;
      if (vif.o_rdReady) sb_push(cyc + 2, pat(15'd50));
      @(negedge clk);
    end
    vif.i_wrValid = 1'b0;
    #1;
    chk("t6_level_3", vif.o_fifoLevel, 3'd3);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    vif.i_rdValid = 1'b0;
    sb.delete();
    b = we_log.size();
    repeat (2) @(negedge clk);
    #1;
    chk("t6_rst_level", vif.o_fifoLevel, 3'd0);
    chk("t6_rst_valid", vif.o_rdDataValid, 1'b0);
    chk("t6_rst_wr_ready", vif.o_wrReady, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      chk("t6_no_rd_valid", vif.o_rdDataValid, 1'b0);
      chk("t6_no_we", vif.o_ramWe, 1'b0);
      chk("t6_level", vif.o_fifoLevel, 3'd0);
    end
    chk("t6_we_log", we_log.size() - b, 0);
    chk("t6_wr_ready", vif.o_wrReady, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
